// File: rtl/mos_result_sorter_pkg.sv
//------------------------------------------------------------------------------
// mos_pkg : shared widths, FSM state encoding and sort-slot record
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mos_pkg;

    localparam int DATA_W  = 40;
    localparam int MAX_LEN = 15;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    typedef struct packed {
        logic                     valid;
        logic signed [DATA_W-1:0] data;
        logic [IDX_W-1:0]         idx;
    } slot_t;

endpackage

`default_nettype wire

// File: rtl/mos_result_sorter_if.sv
//------------------------------------------------------------------------------
// mos_result_sorter_if : burst input and sorted output bundle
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mos_result_sorter_if;
    import mos_pkg::*;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_idx;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  out_idx
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output out_idx
    );

endinterface

`default_nettype wire

// File: rtl/mos_sort_cell.sv
//------------------------------------------------------------------------------
// mos_sort_cell : one slot of the insertion-sort chain
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mos_sort_cell
    import mos_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  clear_i,
    input  wire logic  ins_en_i,
    input  wire logic  shift_i,
    input  wire slot_t new_i,
    input  wire slot_t upper_i,
    output logic       shift_o,
    output slot_t      slot_o
);

    slot_t slot_q;
    slot_t slot_d;
    logic  w_below;

    // Strict compare keeps equal values in arrival order.
    always_comb begin
        w_below = !slot_q.valid || ($signed(new_i.data) > $signed(slot_q.data));
        shift_o = shift_i || w_below;
        slot_d  = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (ins_en_i) begin
            if (shift_i) begin
                slot_d = upper_i;
            end else if (w_below) begin
                slot_d = new_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

`default_nettype wire

// File: rtl/mos_result_sorter.sv
//------------------------------------------------------------------------------
// mos_result_sorter : captures a burst sorted on arrival, replays it descending
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mos_result_sorter
    import mos_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    mos_result_sorter_if.slave bus
);

    state_e                   state_q,     state_d;
    logic [CNT_W-1:0]         count_q,     count_d;
    logic [CNT_W-1:0]         rd_q,        rd_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0]         out_idx_q,   out_idx_d;

    logic                     ins_en;
    logic                     clear;
    slot_t                    new_slot;
    slot_t                    slots [MAX_LEN];
    slot_t                    upper [MAX_LEN];
    logic [MAX_LEN:0]         shift;

    assign shift[0] = 1'b0;
    assign new_slot = '{valid: 1'b1, data: bus.in_data, idx: IDX_W'(count_q)};

    generate
        for (genvar k = 0; k < MAX_LEN; k++) begin : g_cell
            if (k == 0) begin : g_head
                assign upper[k] = '0;
            end else begin : g_link
                assign upper[k] = slots[k-1];
            end

            mos_sort_cell u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear_i  (clear),
                .ins_en_i (ins_en),
                .shift_i  (shift[k]),
                .new_i    (new_slot),
                .upper_i  (upper[k]),
                .shift_o  (shift[k+1]),
                .slot_o   (slots[k])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_idx_d   = '0;
        ins_en      = 1'b0;
        clear       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ins_en  = 1'b1;
                    count_d = CNT_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    // Words beyond capacity are dropped; count saturates.
                    if (count_q < CNT_W'(MAX_LEN)) begin
                        ins_en  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = slots[0].data;
                    out_idx_d   = slots[0].idx;
                    rd_d        = CNT_W'(1);
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (rd_q < count_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = slots[rd_q].data;
                    out_idx_d   = slots[rd_q].idx;
                    rd_d        = rd_q + CNT_W'(1);
                end else begin
                    clear   = 1'b1;
                    count_d = '0;
                    rd_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                clear   = 1'b1;
                count_d = '0;
                rd_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_mos_result_sorter.sv
//------------------------------------------------------------------------------
// tb_mos_result_sorter : directed self-checking bench for mos_result_sorter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mos_result_sorter;
    import mos_pkg::*;

    typedef logic signed [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mos_result_sorter_if bus ();

    mos_result_sorter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    word_t            got_d [$];
    logic [IDX_W-1:0] got_i [$];
    int               first_lat;
    int               zero_viol;

    task automatic drive_burst(input word_t vals [$]);
        foreach (vals[i]) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Records the emitted sequence; optionally injects a stray in_valid pulse.
    task automatic capture(input int pulse_at);
        bit seen = 1'b0;
        bit done = 1'b0;
        got_d.delete();
        got_i.delete();
        first_lat = -1;
        zero_viol = 0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (!seen) first_lat = cyc;
                seen = 1'b1;
                got_d.push_back(bus.out_data);
                got_i.push_back(bus.out_idx);
            end else begin
                if (bus.out_data !== '0 || bus.out_idx !== '0) zero_viol++;
                if (seen) done = 1'b1;
            end
            if (pulse_at > 0 && cyc == pulse_at) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 40'sd100;
            end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid);
        end
        n_tests++;
        if (bus.out_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %0d expected 0", bus.out_data);
        end
        n_tests++;
        if (bus.out_idx !== '0) begin
            n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.out_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst7;
        word_t v  [$] = '{40'sd5, -40'sd3, 40'sd12, 40'sd0, 40'sd12, -40'sd40, 40'sd7};
        word_t ed [$] = '{40'sd12, 40'sd12, 40'sd7, 40'sd5, 40'sd0, -40'sd3, -40'sd40};
        int    ei [$] = '{2, 4, 6, 0, 3, 1, 5};
        drive_burst(v);
        capture(0);
        n_tests++;
        if (first_lat !== 1) begin
            n_fail++; $display("FAIL b7_latency: got %0d expected 1", first_lat);
        end
        n_tests++;
        if (got_d.size() != 7) begin
            n_fail++; $display("FAIL b7_len: got %0d expected 7", got_d.size());
        end
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (i >= got_d.size() || got_d[i] !== ed[i] || int'(got_i[i]) !== ei[i]) begin
                n_fail++;
                $display("FAIL b7_word%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, (i < got_d.size()) ? got_d[i] : word_t'(0),
                         (i < got_i.size()) ? got_i[i] : 4'd0, ed[i], ei[i]);
            end
        end
        n_tests++;
        if (zero_viol != 0) begin
            n_fail++; $display("FAIL b7_idle_zero: got %0d nonzero idle cycles expected 0", zero_viol);
        end
    endtask

    task automatic test_burst15;
        word_t v [$];
        for (int i = 1; i <= 15; i++) v.push_back(word_t'(i));
        drive_burst(v);
        capture(0);
        n_tests++;
        if (got_d.size() != 15) begin
            n_fail++; $display("FAIL b15_len: got %0d expected 15", got_d.size());
        end
        for (int i = 0; i < 15 && i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== word_t'(15 - i) || int'(got_i[i]) !== 14 - i) begin
                n_fail++;
                $display("FAIL b15_word%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, got_d[i], got_i[i], 15 - i, 14 - i);
            end
        end
    endtask

    task automatic test_extremes;
        word_t v  [$] = '{40'h00_0000_0000, 40'h80_0000_0000, 40'h7F_FFFF_FFFF};
        word_t ed [$] = '{40'h7F_FFFF_FFFF, 40'h00_0000_0000, 40'h80_0000_0000};
        int    ei [$] = '{2, 0, 1};
        drive_burst(v);
        capture(0);
        n_tests++;
        if (got_d.size() != 3) begin
            n_fail++; $display("FAIL ext_len: got %0d expected 3", got_d.size());
        end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== ed[i] || int'(got_i[i]) !== ei[i]) begin
                n_fail++;
                $display("FAIL ext_word%0d: got (%h,%0d) expected (%h,%0d)",
                         i, got_d[i], got_i[i], ed[i], ei[i]);
            end
        end
    endtask

    task automatic test_single;
        word_t v [$] = '{-40'sd1};
        drive_burst(v);
        capture(0);
        n_tests++;
        if (got_d.size() != 1 || first_lat !== 1) begin
            n_fail++; $display("FAIL single_len: got %0d words at lat %0d expected 1 at lat 1",
                               got_d.size(), first_lat);
        end
        n_tests++;
        if (got_d.size() < 1 || got_d[0] !== -40'sd1 || got_i[0] !== 4'd0) begin
            n_fail++; $display("FAIL single_word: got (%0d,%0d) expected (-1,0)",
                               (got_d.size() > 0) ? got_d[0] : word_t'(0),
                               (got_i.size() > 0) ? got_i[0] : 4'd0);
        end
    endtask

    task automatic test_reset_mid_collect;
        int    stray = 0;
        word_t v [$] = '{40'sd9, 40'sd4};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = word_t'(50 + i);
        end
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++; $display("FAIL rst_mid_stray: got %0d valid cycles expected 0", stray);
        end
        drive_burst(v);
        capture(0);
        n_tests++;
        if (got_d.size() != 2) begin
            n_fail++; $display("FAIL rst_mid_len: got %0d expected 2", got_d.size());
        end
        n_tests++;
        if (got_d.size() < 2 || got_d[0] !== 40'sd9 || got_i[0] !== 4'd0 ||
            got_d[1] !== 40'sd4 || got_i[1] !== 4'd1) begin
            n_fail++; $display("FAIL rst_mid_words: got %0d words expected (9,0),(4,1)", got_d.size());
        end
    endtask

    task automatic test_overflow;
        word_t v [$];
        int    extra = 0;
        for (int i = 17; i >= 1; i--) v.push_back(word_t'(i));
        drive_burst(v);
        capture(3);
        n_tests++;
        if (got_d.size() != 15) begin
            n_fail++; $display("FAIL ovf_len: got %0d expected 15", got_d.size());
        end
        for (int i = 0; i < 15 && i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== word_t'(17 - i) || int'(got_i[i]) !== i) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, got_d[i], got_i[i], 17 - i, i);
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++; $display("FAIL ovf_extra_burst: got %0d valid cycles expected 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_burst7();
        test_burst15();
        test_extremes();
        test_single();
        test_reset_mid_collect();
        test_overflow();
        test_burst7();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
